// File: rtl/toggle_cover_detect_if.sv
// Signal bundle between the monitored design and the toggle event generator.
// The master side drives the monitored signals and controls; the slave side
// (the detector) returns event pulses and coverage status.
interface toggle_cover_detect_if #(
  parameter int WIDTH = 18,
  parameter int CNT_W = $clog2(2*WIDTH+1)
);
  logic [WIDTH-1:0]   sig_in;
  logic               enable;
  logic               clear;
  logic [2*WIDTH-1:0] valid;
  logic [CNT_W-1:0]   covered_cnt;
  logic               all_covered;
  logic               armed;

  modport master (
    output sig_in, enable, clear,
    input  valid, covered_cnt, all_covered, armed
  );

  modport slave (
    input  sig_in, enable, clear,
    output valid, covered_cnt, all_covered, armed
  );
endinterface

// File: rtl/toggle_cover_detect.sv
// Toggle-event generator: detects rising/falling edges on each monitored bit,
// emits one-cycle pulses on a 2*WIDTH valid vector (bit 2i rise, 2i+1 fall),
// and keeps a sticky map of which toggle points have been hit.
module toggle_cover_detect #(
  parameter int WIDTH         = 18,
  parameter int SETTLE_CYCLES = 2,
  parameter bit FIRST_ONLY    = 1'b1,
  parameter int CNT_W         = $clog2(2*WIDTH+1)
) (
  input logic                 clock,
  input logic                 reset,
  toggle_cover_detect_if.slave bus
);

  localparam int POINTS = 2*WIDTH;

  typedef enum logic [1:0] {IDLE, SETTLE, ARMED} state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        settle_cnt;
  logic [7:0]        settle_next;
  logic [WIDTH-1:0]  prev;
  logic [POINTS-1:0] hit;
  logic [POINTS-1:0] rpt;
  logic [POINTS-1:0] seen;
  logic [POINTS-1:0] seen_next;
  logic [POINTS-1:0] valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_next;
  logic              all_q;

  function automatic logic [CNT_W-1:0] popcount(input logic [POINTS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < POINTS; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Previous-sample register, reloaded every cycle even during reset so the
  // first post-reset comparison never sees a stale value.
  always_ff @(posedge clock) begin
    prev <= bus.sig_in;
  end

  // Per-bit edge detection and the reporting mask (armed, enabled, and
  // optionally only points not yet seen).
  always_comb begin
    hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit[2*i]   = ~prev[i] &  bus.sig_in[i];
      hit[2*i+1] =  prev[i] & ~bus.sig_in[i];
    end
    rpt = hit & {POINTS{(state == ARMED) && bus.enable}};
    if (FIRST_ONLY) begin
      rpt = rpt & ~seen;
    end
  end

  // Next hit map and count; a clear discards history but keeps this cycle's events.
  always_comb begin
    seen_next = seen | rpt;
    cnt_next  = cnt_q + popcount(rpt & ~seen);
    if (bus.clear) begin
      seen_next = rpt;
      cnt_next  = popcount(rpt);
    end
  end

  // Next-state logic: every enable passes through a fresh settle window.
  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          state_next  = SETTLE;
          settle_next = 8'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (!bus.enable) begin
          state_next = IDLE;
        end else if (settle_cnt == 8'd0) begin
          state_next = ARMED;
        end else begin
          settle_next = settle_cnt - 8'd1;
        end
      end
      ARMED: begin
        if (!bus.enable) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pulse outputs and hit tracking registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      settle_cnt <= 8'd0;
      valid_q    <= '0;
      seen       <= '0;
      cnt_q      <= '0;
      all_q      <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      valid_q    <= rpt;
      seen       <= seen_next;
      cnt_q      <= cnt_next;
      all_q      <= (cnt_next == CNT_W'(POINTS));
    end
  end

  assign bus.valid       = valid_q;
  assign bus.covered_cnt = cnt_q;
  assign bus.all_covered = all_q;
  assign bus.armed       = (state == ARMED);

endmodule

// File: tb/tb_toggle_cover_detect.sv
// Scoreboard bench for toggle_cover_detect: one instance with FIRST_ONLY=1 and
// one with FIRST_ONLY=0 share the same stimulus; a reference model predicts
// each edge's outputs and a monitor compares them one cycle later.
module tb_toggle_cover_detect;

  localparam int WIDTH  = 18;
  localparam int POINTS = 2*WIDTH;
  localparam int CNT_W  = $clog2(POINTS+1);
  localparam int SC     = 2;

  typedef struct {
    logic [POINTS-1:0] v1;
    logic [POINTS-1:0] v0;
    logic [CNT_W-1:0]  cnt1;
    logic [CNT_W-1:0]  cnt0;
    logic              all1;
    logic              all0;
    logic              armed;
  } exp_t;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] sig;
  logic             en;
  logic             clr;

  int tests = 0;
  int fails = 0;
  exp_t q[$];

  logic [POINTS-1:0] seen1_m;
  logic [POINTS-1:0] seen0_m;
  logic [WIDTH-1:0]  prev_m;
  int                en_run;
  logic [WIDTH-1:0]  cur;

  toggle_cover_detect_if #(.WIDTH(WIDTH)) if1 ();
  toggle_cover_detect_if #(.WIDTH(WIDTH)) if0 ();

  assign if1.sig_in = sig;
  assign if1.enable = en;
  assign if1.clear  = clr;
  assign if0.sig_in = sig;
  assign if0.enable = en;
  assign if0.clear  = clr;

  toggle_cover_detect #(.WIDTH(WIDTH), .SETTLE_CYCLES(SC), .FIRST_ONLY(1'b1)) dut1 (
    .clock(clock), .reset(reset), .bus(if1.slave)
  );

  toggle_cover_detect #(.WIDTH(WIDTH), .SETTLE_CYCLES(SC), .FIRST_ONLY(1'b0)) dut0 (
    .clock(clock), .reset(reset), .bus(if0.slave)
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's prediction for the next edge.
  task automatic apply_stimulus(input logic [WIDTH-1:0] s, input logic e, input logic c, input logic r);
    exp_t x;
    logic [POINTS-1:0] hit;
    logic armed_before;
    @(negedge clock);
    sig = s; en = e; clr = c; reset = r;
    hit = '0;
    if (!r) begin
      seen1_m = '0;
      seen0_m = '0;
      en_run  = 0;
    end else begin
      armed_before = (en_run >= SC + 1);
      for (int i = 0; i < WIDTH; i++) begin
        if (!prev_m[i] && s[i]) hit[2*i] = 1'b1;
        if (prev_m[i] && !s[i]) hit[2*i+1] = 1'b1;
      end
      if (!(armed_before && e)) hit = '0;
      en_run = e ? ((en_run < 1000) ? en_run + 1 : en_run) : 0;
    end
    x.v0 = hit;
    x.v1 = hit & ~seen1_m;
    if (r) begin
      seen1_m = c ? x.v1 : (seen1_m | x.v1);
      seen0_m = c ? x.v0 : (seen0_m | x.v0);
    end
    prev_m  = s;
    x.cnt1  = CNT_W'($countones(seen1_m));
    x.cnt0  = CNT_W'($countones(seen0_m));
    x.all1  = (x.cnt1 == CNT_W'(POINTS));
    x.all0  = (x.cnt0 == CNT_W'(POINTS));
    x.armed = (en_run >= SC + 1);
    q.push_back(x);
  endtask

  // Monitor: after each edge, compare both instances against the oldest prediction.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check_output("valid_first_only", 64'(if1.valid), 64'(x.v1));
        check_output("valid_every_edge", 64'(if0.valid), 64'(x.v0));
        check_output("cnt_first_only", 64'(if1.covered_cnt), 64'(x.cnt1));
        check_output("cnt_every_edge", 64'(if0.covered_cnt), 64'(x.cnt0));
        check_output("all_first_only", 64'(if1.all_covered), 64'(x.all1));
        check_output("all_every_edge", 64'(if0.all_covered), 64'(x.all0));
        check_output("armed_first_only", 64'(if1.armed), 64'(x.armed));
        check_output("armed_every_edge", 64'(if0.armed), 64'(x.armed));
      end
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    sig = '0; en = 1'b0; clr = 1'b0; reset = 1'b0;
    seen1_m = '0; seen0_m = '0; prev_m = '0; en_run = 0;

    apply_stimulus(18'h0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(18'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(18'h0, 1'b1, 1'b0, 1'b1);

    apply_stimulus(18'h00001, 1'b1, 1'b0, 1'b1);
    apply_stimulus(18'h00001, 1'b1, 1'b0, 1'b1);

    apply_stimulus(18'h00009, 1'b1, 1'b0, 1'b1);
    apply_stimulus(18'h00001, 1'b1, 1'b0, 1'b1);
    apply_stimulus(18'h00009, 1'b1, 1'b0, 1'b1);
    apply_stimulus(18'h00009, 1'b1, 1'b0, 1'b1);

    apply_stimulus(18'h00000, 1'b1, 1'b0, 1'b1);
    apply_stimulus(18'h3FFFF, 1'b1, 1'b0, 1'b1);
    apply_stimulus(18'h00000, 1'b1, 1'b0, 1'b1);
    apply_stimulus(18'h00000, 1'b1, 1'b0, 1'b1);

    apply_stimulus(18'h00020, 1'b1, 1'b1, 1'b1);
    apply_stimulus(18'h00020, 1'b1, 1'b0, 1'b1);

    apply_stimulus(18'h00024, 1'b0, 1'b0, 1'b1);
    apply_stimulus(18'h00020, 1'b0, 1'b0, 1'b1);
    apply_stimulus(18'h00024, 1'b0, 1'b0, 1'b1);
    apply_stimulus(18'h00020, 1'b1, 1'b0, 1'b1);
    apply_stimulus(18'h00024, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(18'h00024, 1'b1, 1'b0, 1'b1);

    apply_stimulus(18'h00100, 1'b1, 1'b0, 1'b0);
    apply_stimulus(18'h00100, 1'b1, 1'b0, 1'b1);

    cur = 18'h00100;
    for (int n = 0; n < 600; n++) begin
      logic r;
      logic e;
      logic c;
      r = ($urandom_range(0, 99) != 0);
      e = ($urandom_range(0, 19) != 0);
      c = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) begin
        cur = WIDTH'($urandom);
      end else begin
        int k;
        k = $urandom_range(0, 3);
        for (int b = 0; b < k; b++) cur[$urandom_range(0, WIDTH-1)] ^= 1'b1;
      end
      apply_stimulus(cur, e, c, r);
    end

    @(negedge clock);
    @(negedge clock);
    check_output("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
